// File: rtl/fp_to_int_pipe.sv
// Three-stage IEEE 754 single-precision to signed integer converter with
// valid/ready flow control: unpack/classify, align, then round/sign/saturate.

module fp2i_unpack (
  input  logic [31:0] a,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        is_denorm
);
  logic exp_max, exp_min, frac_nz;

  assign sign      = a[31];
  assign exp       = a[30:23];
  assign exp_max   = &a[30:23];
  assign exp_min   = ~|a[30:23];
  assign frac_nz   = |a[22:0];
  assign mant      = {~exp_min, a[22:0]};
  assign is_nan    = exp_max & frac_nz;
  assign is_inf    = exp_max & ~frac_nz;
  assign is_zero   = exp_min;
  assign is_denorm = exp_min & frac_nz;
endmodule

module fp2i_align #(
  parameter int OUT_W = 32
) (
  input  logic             sign,
  input  logic [7:0]       exp,
  input  logic [23:0]      mant,
  output logic [OUT_W-1:0] mag,
  output logic             guard,
  output logic             sticky,
  output logic             ovf
);
  localparam logic signed [8:0] UE_SAT = 9'(OUT_W - 1);

  logic signed [8:0] ue;
  logic [4:0]        rsh;
  logic [2:0]        lsh;
  logic [23:0]       lost;
  logic [31:0]       wide;

  assign ue = $signed({1'b0, exp}) - 9'sd127;

  always_comb begin
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    ovf    = 1'b0;
    rsh    = '0;
    lsh    = '0;
    lost   = '0;
    wide   = '0;
    if (ue < 9'sd0) begin
      // Pure fraction: only the half-bit position matters for ue == -1.
      guard  = (ue == -9'sd1);
      sticky = (ue == -9'sd1) ? |mant[22:0] : |mant;
    end else if (ue >= UE_SAT) begin
      // Exactly -2^(OUT_W-1) is representable; everything else saturates.
      if (sign && (ue == UE_SAT) && (mant[22:0] == 23'h0))
        mag = {1'b1, {(OUT_W-1){1'b0}}};
      else
        ovf = 1'b1;
    end else if (ue <= 9'sd23) begin
      rsh    = 5'(9'sd23 - ue);
      lost   = (24'h1 << rsh) - 24'h1;
      wide   = {8'h0, mant >> rsh};
      // Top bit of the discarded field is guard, the rest fold into sticky.
      guard  = |(mant & (lost ^ (lost >> 1)));
      sticky = |(mant & (lost >> 1));
      mag    = wide[OUT_W-1:0];
    end else begin
      lsh  = 3'(ue - 9'sd23);
      wide = {8'h0, mant} << lsh;
      mag  = wide[OUT_W-1:0];
    end
  end
endmodule

module fp2i_round #(
  parameter int OUT_W    = 32,
  parameter bit ROUND_NE = 1'b0
) (
  input  logic             sign,
  input  logic [OUT_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             ovf,
  input  logic             is_nan,
  input  logic             is_inf,
  input  logic             is_zero,
  input  logic             is_denorm,
  output logic [OUT_W-1:0] res,
  output logic             ovf_flag,
  output logic             inv_flag,
  output logic             inx_flag
);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic             inc;
  logic [OUT_W-1:0] mag_r;
  logic             rnd_ovf;

  assign inc     = ROUND_NE && guard && (sticky || mag[0]);
  assign mag_r   = mag + {{(OUT_W-1){1'b0}}, inc};
  // A positive value rounded up into the sign bit no longer fits.
  assign rnd_ovf = !sign && mag_r[OUT_W-1];

  always_comb begin
    res      = '0;
    ovf_flag = 1'b0;
    inv_flag = 1'b0;
    inx_flag = 1'b0;
    if (is_nan) begin
      res      = MAX_POS;
      inv_flag = 1'b1;
    end else if (is_inf || ovf || rnd_ovf) begin
      res      = sign ? MIN_NEG : MAX_POS;
      ovf_flag = 1'b1;
    end else if (is_zero) begin
      inx_flag = is_denorm;
    end else begin
      res      = sign ? -mag_r : mag_r;
      inx_flag = guard | sticky;
    end
  end
endmodule

module fp_to_int_pipe #(
  parameter int OUT_W    = 32,
  parameter bit ROUND_NE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic             invalid,
  output logic             inexact
);
  localparam int STAGES = 3;

  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] adv;
  logic            stall;

  // Each stage advances when it is empty or the stage after it advances,
  // so bubbles ahead of a stalled output are squeezed out.
  assign stall       = vld_pipe[STAGES] && !out_ready;
  assign in_ready    = !stall;
  assign vld_pipe[0] = in_valid && in_ready;
  assign adv[3]      = !vld_pipe[3] || out_ready;
  assign adv[2]      = !vld_pipe[2] || adv[3];
  assign adv[1]      = !vld_pipe[1] || adv[2];
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++)
        if (adv[k]) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Stage 1: unpack / classify
  logic        u_sign, u_nan, u_inf, u_zero, u_denorm;
  logic [7:0]  u_exp;
  logic [23:0] u_mant;

  fp2i_unpack u_unpack (
    .a(a), .sign(u_sign), .exp(u_exp), .mant(u_mant),
    .is_nan(u_nan), .is_inf(u_inf), .is_zero(u_zero), .is_denorm(u_denorm)
  );

  logic        s1_sign, s1_nan, s1_inf, s1_zero, s1_denorm;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_denorm <= 1'b0;
    end else if (adv[1] && vld_pipe[0]) begin
      s1_sign   <= u_sign;
      s1_exp    <= u_exp;
      s1_mant   <= u_mant;
      s1_nan    <= u_nan;
      s1_inf    <= u_inf;
      s1_zero   <= u_zero;
      s1_denorm <= u_denorm;
    end
  end

  // Stage 2: align
  logic [OUT_W-1:0] a_mag;
  logic             a_guard, a_sticky, a_ovf;

  fp2i_align #(.OUT_W(OUT_W)) u_align (
    .sign(s1_sign), .exp(s1_exp), .mant(s1_mant),
    .mag(a_mag), .guard(a_guard), .sticky(a_sticky), .ovf(a_ovf)
  );

  logic             s2_sign, s2_guard, s2_sticky, s2_ovf;
  logic             s2_nan, s2_inf, s2_zero, s2_denorm;
  logic [OUT_W-1:0] s2_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign   <= 1'b0;
      s2_mag    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_denorm <= 1'b0;
    end else if (adv[2] && vld_pipe[1]) begin
      s2_sign   <= s1_sign;
      s2_mag    <= a_mag;
      s2_guard  <= a_guard;
      s2_sticky <= a_sticky;
      s2_ovf    <= a_ovf;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_denorm <= s1_denorm;
    end
  end

  // Stage 3: round / sign / saturate into the output registers
  logic [OUT_W-1:0] r_res;
  logic             r_ovf, r_inv, r_inx;

  fp2i_round #(.OUT_W(OUT_W), .ROUND_NE(ROUND_NE)) u_round (
    .sign(s2_sign), .mag(s2_mag), .guard(s2_guard), .sticky(s2_sticky),
    .ovf(s2_ovf), .is_nan(s2_nan), .is_inf(s2_inf), .is_zero(s2_zero),
    .is_denorm(s2_denorm),
    .res(r_res), .ovf_flag(r_ovf), .inv_flag(r_inv), .inx_flag(r_inx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      inexact  <= 1'b0;
    end else if (adv[3] && vld_pipe[2]) begin
      result   <= r_res;
      overflow <= r_ovf;
      invalid  <= r_inv;
      inexact  <= r_inx;
    end
  end
endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Bench for fp_to_int_pipe: truncating and round-to-nearest-even instances
// driven in lockstep and compared against an arithmetic reference model.

module tb_fp_to_int_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] a;
  logic        in_ready0, out_valid0, ovf0, inv0, inx0;
  logic        in_ready1, out_valid1, ovf1, inv1, inx1;
  logic [31:0] result0, result1;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fp_to_int_pipe #(.OUT_W(32), .ROUND_NE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .overflow(ovf0), .invalid(inv0), .inexact(inx0)
  );

  fp_to_int_pipe #(.OUT_W(32), .ROUND_NE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .overflow(ovf1), .invalid(inv1), .inexact(inx1)
  );

  // Reference: {overflow, invalid, inexact, result} from the exact value
  // mant * 2^(e-150), split into integer part and remainder.
  function automatic logic [34:0] model(input logic [31:0] x, input bit rne);
    longint mant, q, rem, half, v;
    int     e, ue, sh, cmp;
    logic   s;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 255)
      return (x[22:0] != 0) ? {3'b010, 32'h7FFF_FFFF}
                            : {3'b100, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (e == 0) return {2'b00, (x[22:0] != 0), 32'h0};
    mant = longint'({1'b1, x[22:0]});
    ue   = e - 127;
    if (ue >= 40) return {3'b100, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (ue >= 23) begin
      q = mant << (ue - 23); rem = 0; cmp = -1;
    end else begin
      sh = 23 - ue;
      if (sh >= 40) begin
        q = 0; rem = 1; cmp = -1;
      end else begin
        q    = mant >> sh;
        rem  = mant - (q << sh);
        half = longint'(1) << (sh - 1);
        cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
      end
    end
    if (rne && rem != 0 && (cmp > 0 || (cmp == 0 && q[0]))) q = q + 1;
    v = s ? -q : q;
    if (v > 64'sd2147483647 || v < -64'sd2147483648)
      return {3'b100, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    return {2'b00, (rem != 0), v[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp[8] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0005,
                           32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000, 32'hBF00_0000};
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = $urandom_range(0, 9);
    if (k == 0) return $urandom;
    if (k == 1) return sp[$urandom_range(0, 7)];
    e = 8'($urandom_range(110, 160));
    f = 23'($urandom);
    if (k < 5) f = f & 23'h7C_0000;
    return {1'($urandom), e, f};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 00", {out_valid0, out_valid1});
    end
    n_checks++;
    if ({ovf0, inv0, inx0, result0} !== 35'h0 || {ovf1, inv1, inx1, result1} !== 35'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h / %h want 0",
                         {ovf0, inv0, inx0, result0}, {ovf1, inv1, inx1, result1});
    end
    n_checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b%b want 11", in_ready0, in_ready1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ops[18] = '{
      32'hC2F6_0000, 32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000, 32'hCF00_0000,
      32'h4F00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001, 32'h8000_0000,
      32'h3F00_0000, 32'h3F40_0000, 32'hBFC0_0000, 32'hCF00_0001, 32'h4EFF_FFFF,
      32'h7F80_0000, 32'h3F7F_FFFF, 32'h3E80_0000};
    logic [34:0] exp_t[18] = '{
      35'h0_FFFFFF85, 35'h1_00000001, 35'h1_00000002, 35'h1_00000003, 35'h0_80000000,
      35'h4_7FFFFFFF, 35'h4_80000000, 35'h2_7FFFFFFF, 35'h1_00000000, 35'h0_00000000,
      35'h1_00000000, 35'h1_00000000, 35'h1_FFFFFFFF, 35'h4_80000000, 35'h0_7FFFFF80,
      35'h4_7FFFFFFF, 35'h1_00000000, 35'h1_00000000};
    logic [34:0] exp_r[18] = '{
      35'h0_FFFFFF85, 35'h1_00000002, 35'h1_00000002, 35'h1_00000004, 35'h0_80000000,
      35'h4_7FFFFFFF, 35'h4_80000000, 35'h2_7FFFFFFF, 35'h1_00000000, 35'h0_00000000,
      35'h1_00000000, 35'h1_00000001, 35'h1_FFFFFFFE, 35'h4_80000000, 35'h0_7FFFFF80,
      35'h4_7FFFFFFF, 35'h1_00000001, 35'h1_00000000};
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      int lat;
      @(negedge clk); in_valid = 1'b1; a = ops[i];
      @(negedge clk); in_valid = 1'b0; lat = 1;
      while (!out_valid0 && lat < 8) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != 3 || out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d cycles want 3", i, lat);
      end
      n_checks++;
      if ({ovf0, inv0, inx0, result0} !== exp_t[i]) begin
        n_fail++; $display("FAIL directed_trunc[%0d] a=%h: got %h want %h",
                           i, ops[i], {ovf0, inv0, inx0, result0}, exp_t[i]);
      end
      n_checks++;
      if ({ovf1, inv1, inx1, result1} !== exp_r[i]) begin
        n_fail++; $display("FAIL directed_rne[%0d] a=%h: got %h want %h",
                           i, ops[i], {ovf1, inv1, inx1, result1}, exp_r[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[6];
    logic [34:0] e0[6], e1[6];
    logic [34:0] held0, held1;
    int          sent, got;
    bit          prev_stall;
    for (int i = 0; i < 6; i++) begin
      ops[i] = rand_op(); e0[i] = model(ops[i], 1'b0); e1[i] = model(ops[i], 1'b1);
    end
    sent = 0; got = 0; prev_stall = 1'b0; held0 = '0; held1 = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (sent < 6);
      if (sent < 6) a = ops[sent];
      #1;
      if (prev_stall) begin
        n_checks++;
        if (!out_valid0 || {ovf0, inv0, inx0, result0} !== held0 ||
            {ovf1, inv1, inx1, result1} !== held1) begin
          n_fail++; $display("FAIL b2b_hold cyc %0d: got %h/%h want %h/%h", c,
                             {ovf0, inv0, inx0, result0}, {ovf1, inv1, inx1, result1}, held0, held1);
        end
      end
      if (out_valid0 && !out_ready) begin
        n_checks++;
        if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
          n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b%b want 00", c, in_ready0, in_ready1);
        end
      end
      if (out_valid0 && out_ready) begin
        n_checks++;
        if ({ovf0, inv0, inx0, result0} !== e0[got] || {ovf1, inv1, inx1, result1} !== e1[got]) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got %h/%h want %h/%h", got,
                             {ovf0, inv0, inx0, result0}, {ovf1, inv1, inx1, result1}, e0[got], e1[got]);
        end
        got++;
      end
      if (in_valid && in_ready0) sent++;
      prev_stall = out_valid0 && !out_ready;
      held0 = {ovf0, inv0, inx0, result0};
      held1 = {ovf1, inv1, inx1, result1};
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 6", got);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drained: out_valid %b want 0", out_valid0);
    end
  endtask

  task automatic test_random();
    logic [34:0] q0[$], q1[$];
    logic [34:0] ex0, ex1, held0, held1;
    bit          prev_stall, stall;
    prev_stall = 1'b0; held0 = '0; held1 = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      out_ready = (c >= 560) || ($urandom_range(0, 3) != 0);
      in_valid  = (c < 560) && ($urandom_range(0, 3) != 0);
      a         = rand_op();
      #1;
      stall = out_valid0 && !out_ready;
      n_checks++;
      if (in_ready0 !== !stall || in_ready1 !== !stall || out_valid1 !== out_valid0) begin
        n_fail++; $display("FAIL rand_handshake cyc %0d: in_ready %b%b out_valid %b%b stall %b",
                           c, in_ready0, in_ready1, out_valid0, out_valid1, stall);
      end
      if (prev_stall) begin
        n_checks++;
        if ({ovf0, inv0, inx0, result0} !== held0 || {ovf1, inv1, inx1, result1} !== held1) begin
          n_fail++; $display("FAIL rand_hold cyc %0d: got %h/%h want %h/%h", c,
                             {ovf0, inv0, inx0, result0}, {ovf1, inv1, inx1, result1}, held0, held1);
        end
      end
      if (out_valid0 && out_ready) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected cyc %0d: got result %h want none", c, result0);
        end else begin
          ex0 = q0.pop_front(); ex1 = q1.pop_front();
          if ({ovf0, inv0, inx0, result0} !== ex0 || {ovf1, inv1, inx1, result1} !== ex1) begin
            n_fail++; $display("FAIL rand_result cyc %0d: got %h/%h want %h/%h", c,
                               {ovf0, inv0, inx0, result0}, {ovf1, inv1, inx1, result1}, ex0, ex1);
          end
        end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(model(a, 1'b0)); q1.push_back(model(a, 1'b1));
      end
      prev_stall = stall;
      held0 = {ovf0, inv0, inx0, result0};
      held1 = {ovf1, inv1, inx1, result1};
    end
    in_valid = 1'b0;
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: %0d results outstanding want 0", q0.size());
    end
  endtask

  task automatic test_reset_flush();
    int lat, extra;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; a = 32'h42F6_0000;
    @(negedge clk); a = 32'h3FC0_0000;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup: out_valid %b want 1", out_valid0);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || result0 !== 32'h0 || result1 !== 32'h0) begin
      n_fail++; $display("FAIL flush_async: out_valid %b%b result %h/%h want 00 0/0",
                         out_valid0, out_valid1, result0, result1);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; a = 32'h4060_0000;
    @(negedge clk); in_valid = 1'b0; lat = 1;
    while (!out_valid0 && lat < 8) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != 3) begin
      n_fail++; $display("FAIL flush_latency: got %0d cycles want 3", lat);
    end
    n_checks++;
    if ({ovf0, inv0, inx0, result0} !== 35'h1_00000003 ||
        {ovf1, inv1, inx1, result1} !== 35'h1_00000004) begin
      n_fail++; $display("FAIL flush_result: got %h/%h want 100000003/100000004",
                         {ovf0, inv0, inx0, result0}, {ovf1, inv1, inx1, result1});
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++; $display("FAIL flush_leftover: got %0d extra results want 0", extra);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0;
    #2;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
